// File: rtl/ram_bus_arbiter_if.sv
// Shared bus between the client stages, the RAM arbiter and the RAM controller.
// Client addresses and write data are packed, client i in slice i.
interface ram_bus_arbiter_if #(
  parameter int NUM_CLIENTS = 4
);
  logic [NUM_CLIENTS-1:0]    cli_req;
  logic [NUM_CLIENTS-1:0]    cli_instr;
  logic [23*NUM_CLIENTS-1:0] cli_addr;
  logic [16*NUM_CLIENTS-1:0] cli_wdata;
  logic [NUM_CLIENTS-1:0]    cli_grant;
  logic [NUM_CLIENTS-1:0]    cli_done;
  logic [15:0]               cli_rdata;
  logic                      cli_err;
  logic                      ram_instruction;
  logic                      ram_latch;
  logic [22:0]               ram_addr;
  logic [15:0]               ram_wdata;
  logic [15:0]               ram_rdata;
  logic                      ram_ready;

  // Arbiter side: owns grant/done/rdata toward the clients and the command toward the RAM.
  modport master (
    input  cli_req, cli_instr, cli_addr, cli_wdata, ram_rdata, ram_ready,
    output cli_grant, cli_done, cli_rdata, cli_err,
    output ram_instruction, ram_latch, ram_addr, ram_wdata
  );

  // Environment side: the client stages plus the RAM controller.
  modport slave (
    output cli_req, cli_instr, cli_addr, cli_wdata, ram_rdata, ram_ready,
    input  cli_grant, cli_done, cli_rdata, cli_err,
    input  ram_instruction, ram_latch, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter serialising client RAM requests onto the single RAM
// controller port: one latch strobe per transaction, a done pulse back to the
// owner, and a timeout that forces completion with an error flag.
module ram_bus_arbiter #(
  parameter int NUM_CLIENTS    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  ram_bus_arbiter_if.master bus
);

  localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT,
    COMPLETE
  } state_t;

  state_t state, state_next;

  logic [PTR_W-1:0]       last_ptr;
  logic [PTR_W-1:0]       owner;
  logic [PTR_W-1:0]       sel;
  logic [PTR_W-1:0]       cand;
  logic                   sel_valid;
  logic [NUM_CLIENTS-1:0] grant;
  logic                   instr_q;
  logic [22:0]            addr_q;
  logic [15:0]            wdata_q;
  logic [15:0]            rdata_q;
  logic [CNT_W-1:0]       wait_cnt;
  logic                   err_flag;
  logic                   timed_out;

  logic [22:0] addr_arr  [NUM_CLIENTS];
  logic [15:0] wdata_arr [NUM_CLIENTS];

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign addr_arr[g]  = bus.cli_addr[23*g +: 23];
    assign wdata_arr[g] = bus.cli_wdata[16*g +: 16];
  end

  // Last WAIT cycle before the wait budget is exhausted.
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Round-robin pick: first requester after the last owner, wrapping, so the last owner ranks lowest.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      cand = PTR_W'((int'(last_ptr) + k) % NUM_CLIENTS);
      if (!sel_valid && bus.cli_req[cand]) begin
        sel       = cand;
        sel_valid = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; ready is only looked at in IDLE and WAIT since the controller drops it after a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (sel_valid && bus.ram_ready) state_next = ISSUE;
      ISSUE:    state_next = SETTLE;
      SETTLE:   state_next = WAIT;
      WAIT:     if (bus.ram_ready || timed_out) state_next = COMPLETE;
      COMPLETE: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Strobes decoded from the state: latch in ISSUE, done/err toward the owner in COMPLETE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    bus.ram_latch = 1'b0;
    bus.cli_done  = '0;
    bus.cli_err   = 1'b0;
    case (state)
      ISSUE: bus.ram_latch = 1'b1;
      COMPLETE: begin
        bus.cli_done = grant;
        bus.cli_err  = err_flag;
      end
      default: ;
    endcase
  end

  // Transaction registers: grant/command capture, wait counter, read data and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant    <= '0;
      owner    <= '0;
      last_ptr <= PTR_W'(NUM_CLIENTS - 1);
      instr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wait_cnt <= '0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid && bus.ram_ready) begin
            grant   <= NUM_CLIENTS'(1) << sel;
            owner   <= sel;
            instr_q <= bus.cli_instr[sel];
            addr_q  <= addr_arr[sel];
            wdata_q <= wdata_arr[sel];
          end
        end
        SETTLE: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (bus.ram_ready) begin
            if (!instr_q) rdata_q <= bus.ram_rdata;
          end else if (timed_out) begin
            err_flag <= 1'b1;
          end
        end
        COMPLETE: begin
          last_ptr <= owner;
          grant    <= '0;
          err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.cli_grant       = grant;
  assign bus.cli_rdata       = rdata_q;
  assign bus.ram_instruction = instr_q;
  assign bus.ram_addr        = addr_q;
  assign bus.ram_wdata       = wdata_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: a transaction-level round-robin model plus a
// behavioural RAM controller that stretches ready low for a chosen time.
module tb_ram_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 255;

  typedef logic [$clog2(N)-1:0] cidx_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  ram_bus_arbiter_if #(.NUM_CLIENTS(N)) bus ();

  ram_bus_arbiter #(
    .NUM_CLIENTS   (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Rising-edge count; at a falling edge it names the cycle currently in progress.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Client stimulus, wired onto the packed bus.
  logic [N-1:0] req_v = '0;
  logic         instr_v [N];
  logic [22:0]  addr_v  [N];
  logic [15:0]  wdata_v [N];

  assign bus.cli_req = req_v;
  for (genvar g = 0; g < N; g++) begin : g_drv
    assign bus.cli_instr[g]          = instr_v[g];
    assign bus.cli_addr[23*g +: 23]  = addr_v[g];
    assign bus.cli_wdata[16*g +: 16] = wdata_v[g];
  end

  // RAM controller model.
  logic        ctrl_ready  = 1'b1;
  logic [15:0] ctrl_rdata  = '0;
  logic        ready_block = 1'b0;
  bit          hold_low    = 1'b0;
  int          busy_cycles = 0;
  logic [15:0] ram_mem [logic [22:0]];

  assign bus.ram_ready = ctrl_ready & ~ready_block;
  assign bus.ram_rdata = ctrl_rdata;

  // On a latch, perform the access, drop ready, and hold it low for busy_cycles WAIT cycles
  // (or until hold_low is released), then present the read data with ready.
  initial begin : responder
    logic [22:0] a;
    logic [15:0] d;
    ram_mem[23'h5] = 16'h1234;
    forever begin
      @(negedge clk);
      if (bus.ram_latch) begin
        a = bus.ram_addr;
        if (bus.ram_instruction) begin
          ram_mem[a] = bus.ram_wdata;
          d = 16'hDEAD;
        end else begin
          d = ram_mem.exists(a) ? ram_mem[a] : 16'h0000;
        end
        ctrl_ready = 1'b0;
        if (hold_low) while (hold_low) @(negedge clk);
        else repeat (busy_cycles + 2) @(negedge clk);
        ctrl_rdata = d;
        ctrl_ready = 1'b1;
      end
    end
  end

  // Reference model state.
  logic [15:0] ref_mem [logic [22:0]];
  int          ref_ptr   = N - 1;
  logic [15:0] exp_rdata = '0;
  cidx_t       last_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Next owner: walk clients starting just after the previous owner, wrapping around.
  function automatic cidx_t rr_pick(input logic [N-1:0] pend, input int ptr);
    cidx_t ci;
    for (int k = 1; k <= N; k++) begin
      ci = cidx_t'((ptr + k) % N);
      if (pend[ci]) return ci;
    end
    return cidx_t'(0);
  endfunction

  task automatic tick();
    @(negedge clk);
    check("grant_onehot0", 32'($onehot0(bus.cli_grant)), 32'd1);
    check("done_onehot0",  32'($onehot0(bus.cli_done)),  32'd1);
  endtask

  task automatic set_client(input cidx_t c, input logic instr, input logic [22:0] a, input logic [15:0] d);
    instr_v[c] = instr;
    addr_v[c]  = a;
    wdata_v[c] = d;
    req_v[c]   = 1'b1;
  endtask

  task automatic set_random(input cidx_t c);
    set_client(c, 1'($urandom_range(0, 1)), 23'($urandom_range(0, 7)), 16'($urandom));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_grant"},  32'(bus.cli_grant),       32'd0);
    check({tag, "_done"},   32'(bus.cli_done),        32'd0);
    check({tag, "_err"},    32'(bus.cli_err),         32'd0);
    check({tag, "_rdata"},  32'(bus.cli_rdata),       32'd0);
    check({tag, "_latch"},  32'(bus.ram_latch),       32'd0);
    check({tag, "_instr"},  32'(bus.ram_instruction), 32'd0);
    check({tag, "_addr"},   32'(bus.ram_addr),        32'd0);
    check({tag, "_wdata"},  32'(bus.ram_wdata),       32'd0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_v = '0;
    for (int i = 0; i < N; i++) begin
      instr_v[i] = 1'b0;
      addr_v[i]  = '0;
      wdata_v[i] = '0;
    end
    repeat (2) tick();
    check_outputs_zero("reset");
    rst       = 1'b0;
    ref_ptr   = N - 1;
    exp_rdata = '0;
  endtask

  // One whole transaction against the model. With chk_lat set, t_req is the cycle in which
  // the request (with ready high) is first presented: the latch occupies the following cycle,
  // so the controller samples it on the second rising edge after the request.
  task automatic serve(input int busy, input bit exp_err, input int t_req, input bit chk_lat);
    cidx_t       w;
    logic [22:0] ea;
    logic [15:0] ew;
    logic        ei;
    bit          got;
    int          tl;
    int          td;
    w  = rr_pick(req_v, ref_ptr);
    ea = addr_v[w];
    ew = wdata_v[w];
    ei = instr_v[w];
    busy_cycles = busy;

    got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      tick();
      got = bus.ram_latch;
    end
    check("latch_seen", 32'(got), 32'd1);
    tl = cyc;
    if (chk_lat) check("req_to_latch", 32'(tl - t_req), 32'd1);
    check("grant_owner", 32'(bus.cli_grant),       32'd1 << w);
    check("ram_addr",    32'(bus.ram_addr),        32'(ea));
    check("ram_wdata",   32'(bus.ram_wdata),       32'(ew));
    check("ram_instr",   32'(bus.ram_instruction), 32'(ei));

    got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      tick();
      got = (bus.cli_done != '0);
    end
    check("done_seen", 32'(got), 32'd1);
    td = cyc;
    check("latch_to_done", 32'(td - tl), exp_err ? 32'(TO + 2) : 32'(busy + 3));
    check("done_owner", 32'(bus.cli_done), 32'd1 << w);
    check("done_err",   32'(bus.cli_err),  32'(exp_err));
    check("addr_stable", 32'(bus.ram_addr), 32'(ea));

    if (ei) ref_mem[ea] = ew;
    else if (!exp_err) exp_rdata = ref_mem.exists(ea) ? ref_mem[ea] : 16'h0000;
    check("rdata", 32'(bus.cli_rdata), 32'(exp_rdata));

    ref_ptr  = int'(w);
    last_w   = w;
    req_v[w] = 1'b0;
  endtask

  initial begin : main
    int  t_req;
    int  served [N];
    bit  got;

    ref_mem[23'h5] = 16'h1234;
    do_reset();

    // Single write from client 0 with ready held high.
    set_client(cidx_t'(0), 1'b1, 23'h000010, 16'hBEEF);
    t_req = cyc;
    serve(0, 1'b0, t_req, 1'b1);

    // Read from client 2 with a 4-cycle busy controller, then a write that must not disturb rdata.
    set_client(cidx_t'(2), 1'b0, 23'h000005, 16'h0000);
    serve(4, 1'b0, 0, 1'b0);
    check("read_rdata", 32'(bus.cli_rdata), 32'h1234);
    set_random(cidx_t'(1));
    instr_v[1] = 1'b1;
    serve(int'($urandom_range(0, 3)), 1'b0, 0, 1'b0);
    check("rdata_hold_after_write", 32'(bus.cli_rdata), 32'h1234);

    // All clients request together and re-request once after each done.
    do_reset();
    for (int i = 0; i < N; i++) begin
      served[i] = 0;
      set_random(cidx_t'(i));
    end
    for (int k = 0; k < 2 * N; k++) begin
      serve(int'($urandom_range(0, 3)), 1'b0, 0, 1'b0);
      check("rotation_order", 32'(last_w), 32'(k % N));
      served[last_w]++;
      if (served[last_w] < 2) set_random(last_w);
    end

    // Controller never returns ready: timeout with error, then a normal transaction.
    hold_low = 1'b1;
    set_client(cidx_t'(3), 1'b0, 23'h000007, 16'h0000);
    serve(0, 1'b1, 0, 1'b0);
    hold_low = 1'b0;
    set_client(cidx_t'(1), 1'b1, 23'h000002, 16'($urandom));
    serve(1, 1'b0, 0, 1'b0);

    // Ready low when the request arrives: no latch until ready returns.
    ready_block = 1'b1;
    set_client(cidx_t'(2), 1'b1, 23'h000006, 16'($urandom));
    for (int k = 0; k < 6; k++) begin
      tick();
      check("no_latch_while_busy", 32'(bus.ram_latch), 32'd0);
    end
    ready_block = 1'b0;
    t_req = cyc;
    serve(0, 1'b0, t_req, 1'b1);

    // Asynchronous reset while WAITing: outputs drop at once, no done, client 0 first afterwards.
    hold_low = 1'b1;
    set_client(cidx_t'(1), 1'b0, 23'h000003, 16'h0000);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      tick();
      got = bus.ram_latch;
    end
    check("latch_before_reset", 32'(got), 32'd1);
    repeat (3) tick();
    check("grant_in_wait", 32'(bus.cli_grant), 32'h2);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_reset");
    repeat (3) begin
      tick();
      check("no_done_in_reset", 32'(bus.cli_done), 32'd0);
    end
    hold_low = 1'b0;
    repeat (2) tick();
    rst       = 1'b0;
    ref_ptr   = N - 1;
    exp_rdata = '0;
    set_random(cidx_t'(0));
    set_random(cidx_t'(2));
    serve(0, 1'b0, 0, 1'b0);
    check("first_after_reset", 32'(last_w), 32'd0);
    serve(2, 1'b0, 0, 1'b0);
    serve(0, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
